axis_differentiator_ctrl: RTL and testbench

Sequencer for the streaming differentiator datapath. It drives the datapath's reset and enable, and post-processes the datapath's output stream. When differentiation is switched on, it flushes the datapath pipeline, then blanks the output until the FIR history holds only fresh samples. This keeps stale or mixed-mode samples from ever reaching the downstream velocity/displacement chain. The output sample rate is unchanged: blanked samples are emitted as zero, never dropped.

---
 rtl/axis_differentiator_ctrl.sv | 75 +++++++
 tb/tb_axis_differentiator_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/axis_differentiator_ctrl.sv
// axis_differentiator_ctrl: flushes and settles the differentiator datapath, blanking its stream until the history is fresh
module axis_differentiator_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CLEAR_CYCLES     = 2,
    parameter int SETTLE_SAMPLES   = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_enable,
    input  logic                        cfg_restart,
    output logic                        dp_aresetn,
    output logic                        dp_enable,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic [1:0]                  status_state,
    output logic [15:0]                 restart_count
);
    typedef enum logic [1:0] {BYPASS, CLEAR, SETTLE, ACTIVE} state_t;
    localparam int CW = $clog2((CLEAR_CYCLES > SETTLE_SAMPLES ? CLEAR_CYCLES : SETTLE_SAMPLES) + 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_SAMPLES - 1);
    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_dp_aresetn, r_dp_enable;
    logic [15:0]   r_restart_count;
    logic          w_enter_clear;
    logic          w_unused;
    assign w_unused      = M_AXIS_tready;
    // a restart pulse only re-flushes while enabled; BYPASS enters CLEAR on enable alone
    assign w_enter_clear = cfg_enable && (r_state == BYPASS || cfg_restart);
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!cfg_enable) begin
            w_state_next = BYPASS;
            w_cnt_next   = '0;
        end else if (w_enter_clear) begin
            w_state_next = CLEAR;
            w_cnt_next   = '0;
        end else if (r_state == CLEAR) begin
            w_state_next = (r_cnt == CLR_LAST) ? SETTLE : CLEAR;
            w_cnt_next   = (r_cnt == CLR_LAST) ? '0 : r_cnt + 1'b1;
        end else if (r_state == SETTLE && S_AXIS_tvalid) begin
            w_state_next = (r_cnt == SET_LAST) ? ACTIVE : SETTLE;
            w_cnt_next   = (r_cnt == SET_LAST) ? '0 : r_cnt + 1'b1;
        end
    end
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state         <= BYPASS;
            r_cnt           <= '0;
            r_dp_aresetn    <= 1'b0;
            r_dp_enable     <= 1'b0;
            r_restart_count <= '0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_dp_aresetn    <= (w_state_next != CLEAR);
            r_dp_enable     <= (w_state_next == SETTLE || w_state_next == ACTIVE);
            if (w_enter_clear && r_restart_count != 16'hFFFF)
                r_restart_count <= r_restart_count + 16'd1;
        end
    end
    assign dp_aresetn    = r_dp_aresetn;
    assign dp_enable     = r_dp_enable;
    assign S_AXIS_tready = 1'b1;
    assign M_AXIS_tvalid = S_AXIS_tvalid;
    assign M_AXIS_tdata  = (r_state == CLEAR || r_state == SETTLE) ? '0 : S_AXIS_tdata;
    assign status_state  = r_state;
    assign restart_count = r_restart_count;
endmodule

// File: tb/tb_axis_differentiator_ctrl.sv
// tb_axis_differentiator_ctrl: directed checks of flush/settle sequencing, blanking and restart counting
module tb_axis_differentiator_ctrl;
    logic        aclk = 1'b0;
    logic        aresetn, cfg_enable, cfg_restart;
    logic        dp_aresetn, dp_enable;
    logic        s_tvalid, s_tready, m_tready, m_tvalid;
    logic [15:0] s_tdata, m_tdata, restart_count;
    logic [1:0]  status_state;
    int          n_chk = 0;
    int          n_err = 0;

    axis_differentiator_ctrl #(.AXIS_TDATA_WIDTH(16), .CLEAR_CYCLES(2), .SETTLE_SAMPLES(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_enable(cfg_enable), .cfg_restart(cfg_restart),
        .dp_aresetn(dp_aresetn), .dp_enable(dp_enable),
        .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(s_tready),
        .M_AXIS_tready(m_tready), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tdata(m_tdata),
        .status_state(status_state), .restart_count(restart_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        cfg_enable = 1'b0;
        cfg_restart = 1'b0;
        step();
        aresetn = 1'b1;
    endtask

    // cfg_enable must already be 1; tvalid fires on edges j with j%p == 2%p, counted from the enabling edge
    task automatic run_flush(input int p, input int exp_settle);
        int n_clear = 0;
        int n_settle = 0;
        int bad = 0;
        logic done = 1'b0;
        for (int j = 0; j < 200 && !done; j++) begin
            s_tvalid = (j % p == 2 % p);
            s_tdata  = 16'h1000 + 16'(j);
            step();
            if (status_state == 2'd1) n_clear++;
            if (status_state == 2'd2) n_settle++;
            if (dp_aresetn !== (status_state != 2'd1)) bad++;
            if (dp_enable !== (status_state >= 2'd2)) bad++;
            if (m_tvalid !== s_tvalid) bad++;
            if (m_tdata !== ((status_state == 2'd1 || status_state == 2'd2) ? 16'h0 : s_tdata)) bad++;
            done = (status_state == 2'd3);
        end
        check("clear_len", n_clear, 2);
        check("settle_len", n_settle, exp_settle);
        check("ctl_consistency", bad, 0);
        check("active_reached", {30'd0, status_state}, 3);
    endtask

    initial begin
        aresetn = 1'b0; cfg_enable = 1'b0; cfg_restart = 1'b0;
        s_tvalid = 1'b1; s_tdata = 16'h1234; m_tready = 1'b0;
        step(); step();
        check("rst_state", {30'd0, status_state}, 0);
        check("rst_dp_aresetn", {31'd0, dp_aresetn}, 0);
        check("rst_dp_enable", {31'd0, dp_enable}, 0);
        check("rst_restart_count", {16'd0, restart_count}, 0);
        check("rst_m_tdata", {16'd0, m_tdata}, 32'h1234);
        check("rst_m_tvalid", {31'd0, m_tvalid}, 1);
        check("s_tready", {31'd0, s_tready}, 1);
        aresetn = 1'b1;
        step();
        check("t1_dp_aresetn", {31'd0, dp_aresetn}, 1);
        check("t1_dp_enable", {31'd0, dp_enable}, 0);
        check("t1_state", {30'd0, status_state}, 0);
        check("t1_m_tdata", {16'd0, m_tdata}, 32'h1234);
        // continuous valid: 2 CLEAR, 8 SETTLE
        cfg_enable = 1'b1;
        run_flush(1, 8);
        check("t2_restart_count", {16'd0, restart_count}, 1);
        s_tdata = 16'h5A5A;
        #1;
        check("t2_active_pass", {16'd0, m_tdata}, 32'h5A5A);
        // 1-in-4 valid: SETTLE stretches to 32 clocks
        do_reset();
        cfg_enable = 1'b1;
        run_flush(4, 32);
        check("t3_restart_count", {16'd0, restart_count}, 1);
        // disable after 3 settle samples
        do_reset();
        cfg_enable = 1'b1;
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("t4_mid_settle", {30'd0, status_state}, 2);
        cfg_enable = 1'b0;
        s_tdata = 16'hBEEF;
        step();
        check("t4_bypass", {30'd0, status_state}, 0);
        check("t4_dp_enable", {31'd0, dp_enable}, 0);
        check("t4_dp_aresetn", {31'd0, dp_aresetn}, 1);
        check("t4_raw_pass", {16'd0, m_tdata}, 32'hBEEF);
        cfg_enable = 1'b1;
        run_flush(1, 8);
        check("t4_restart_count", {16'd0, restart_count}, 2);
        // restart with disable wins as disable
        cfg_restart = 1'b1; cfg_enable = 1'b0;
        step();
        cfg_restart = 1'b0;
        check("t5_dis_restart_state", {30'd0, status_state}, 0);
        check("t5_dis_restart_count", {16'd0, restart_count}, 2);
        cfg_enable = 1'b1;
        run_flush(1, 8);
        check("t5_reenable_count", {16'd0, restart_count}, 3);
        cfg_restart = 1'b1;
        step();
        cfg_restart = 1'b0;
        check("t5_restart_state", {30'd0, status_state}, 1);
        check("t5_restart_count", {16'd0, restart_count}, 4);
        check("t5_restart_dp_aresetn", {31'd0, dp_aresetn}, 0);
        check("t5_restart_blank", {16'd0, m_tdata}, 0);
        step();
        cfg_restart = 1'b1;
        step();
        cfg_restart = 1'b0;
        check("t5_clear_restart_state", {30'd0, status_state}, 1);
        check("t5_clear_restart_count", {16'd0, restart_count}, 5);
        cfg_enable = 1'b0;
        step();
        cfg_restart = 1'b1;
        step();
        cfg_restart = 1'b0;
        check("t5_bypass_restart_state", {30'd0, status_state}, 0);
        check("t5_bypass_restart_count", {16'd0, restart_count}, 5);
        // reset mid-settle aborts, then enable restarts a flush
        cfg_enable = 1'b1;
        s_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t6_pre_state", {30'd0, status_state}, 2);
        aresetn = 1'b0;
        step();
        check("t6_rst_state", {30'd0, status_state}, 0);
        check("t6_rst_dp_aresetn", {31'd0, dp_aresetn}, 0);
        check("t6_rst_dp_enable", {31'd0, dp_enable}, 0);
        check("t6_rst_count", {16'd0, restart_count}, 0);
        aresetn = 1'b1;
        step();
        check("t6_reflush_state", {30'd0, status_state}, 1);
        check("t6_reflush_count", {16'd0, restart_count}, 1);
        check("t6_reflush_dp_aresetn", {31'd0, dp_aresetn}, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
